// File: rtl/core_pkg.sv
// Shared encodings for the RV32I execute stage: ALU, branch, memory and forwarding selects.
package core_pkg;
  localparam int XLEN = 32;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_LUI   = 4'd10,
    ALU_AUIPC = 4'd11,
    ALU_NOP   = 4'd15
  } alu_op_e;

  typedef enum logic [3:0] {
    BR_NONE = 4'd0,
    BR_BEQ  = 4'd1,
    BR_BNE  = 4'd2,
    BR_BLT  = 4'd3,
    BR_BGE  = 4'd4,
    BR_BLTU = 4'd5,
    BR_BGEU = 4'd6,
    BR_JAL  = 4'd7,
    BR_JALR = 4'd8
  } br_op_e;

  typedef enum logic [3:0] {
    MEM_NOP = 4'd0,
    MEM_LB  = 4'd1,
    MEM_LH  = 4'd2,
    MEM_LW  = 4'd3,
    MEM_LBU = 4'd4,
    MEM_LHU = 4'd5,
    MEM_SB  = 4'd6,
    MEM_SH  = 4'd7,
    MEM_SW  = 4'd8
  } mem_op_e;

  typedef enum logic [1:0] {
    FW_RF   = 2'd0,
    FW_MEM  = 2'd1,
    FW_WB   = 2'd2,
    FW_RF_3 = 2'd3
  } fw_sel_e;

  localparam logic [3:0] ALU_OP_NOP = ALU_NOP;
  localparam logic [3:0] MEM_OP_NOP = MEM_NOP;
  localparam logic [3:0] BR_OP_NOP  = BR_NONE;
endpackage

// File: rtl/ex_alu.sv
// Pure combinational RV32I ALU; 0-cycle latency, no flow control.
module ex_alu
  import core_pkg::*;
(
  input  logic [3:0]      i_op,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  input  logic [XLEN-1:0] i_pc,
  output logic [XLEN-1:0] o_res
);
  logic [4:0] w_shamt;
  assign w_shamt = i_b[4:0];

  always_comb begin
    o_res = '0;
    case (i_op)
      ALU_ADD:   o_res = i_a + i_b;
      ALU_SUB:   o_res = i_a - i_b;
      ALU_SLL:   o_res = i_a << w_shamt;
      ALU_SLT:   o_res = {31'b0, $signed(i_a) < $signed(i_b)};
      ALU_SLTU:  o_res = {31'b0, i_a < i_b};
      ALU_XOR:   o_res = i_a ^ i_b;
      ALU_SRL:   o_res = i_a >> w_shamt;
      ALU_SRA:   o_res = $unsigned($signed(i_a) >>> w_shamt);
      ALU_OR:    o_res = i_a | i_b;
      ALU_AND:   o_res = i_a & i_b;
      ALU_LUI:   o_res = i_b;
      ALU_AUIPC: o_res = i_pc + i_b;
      default:   o_res = '0;
    endcase
  end
endmodule

// File: rtl/ex_branch.sv
// Branch/jump resolution: condition, redirect target, link value and flush.
// Fully combinational (0-cycle); the front end must honour flush in the same cycle.
module ex_branch
  import core_pkg::*;
(
  input  logic            i_valid,
  input  logic [3:0]      i_op,
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b2,
  input  logic [XLEN-1:0] i_imm,
  output logic            o_flush,
  output logic [XLEN-1:0] o_target,
  output logic            o_is_jump,
  output logic [XLEN-1:0] o_link
);
  logic            w_taken;
  logic [XLEN-1:0] w_jalr_sum;

  assign w_jalr_sum = i_a + i_imm;

  always_comb begin
    w_taken = 1'b0;
    case (i_op)
      BR_BEQ:  w_taken = (i_a == i_b2);
      BR_BNE:  w_taken = (i_a != i_b2);
      BR_BLT:  w_taken = ($signed(i_a) <  $signed(i_b2));
      BR_BGE:  w_taken = ($signed(i_a) >= $signed(i_b2));
      BR_BLTU: w_taken = (i_a <  i_b2);
      BR_BGEU: w_taken = (i_a >= i_b2);
      BR_JAL:  w_taken = 1'b1;
      BR_JALR: w_taken = 1'b1;
      default: w_taken = 1'b0;
    endcase
  end

  assign o_is_jump = (i_op == BR_JAL) || (i_op == BR_JALR);
  assign o_link    = i_pc + 32'd4;
  assign o_flush   = i_valid & w_taken;

  // Target is zeroed when not redirecting so downstream never sees stale addresses.
  always_comb begin
    o_target = '0;
    if (o_flush)
      o_target = (i_op == BR_JALR) ? {w_jalr_sum[XLEN-1:1], 1'b0} : (i_pc + i_imm);
  end
endmodule

// File: rtl/ex_lsu_ctl.sv
// Data-memory request builder: address, byte enables, store data, misalignment.
// Combinational (0-cycle); a misaligned access is demoted to a NOP request.
module ex_lsu_ctl
  import core_pkg::*;
(
  input  logic [3:0]      i_op,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_imm,
  input  logic [XLEN-1:0] i_b2,
  output logic [XLEN-1:0] o_addr,
  output logic [3:0]      o_be,
  output logic [XLEN-1:0] o_wdata,
  output logic            o_misalign,
  output logic [3:0]      o_op
);
  logic w_byte, w_half, w_word;

  assign o_addr = i_a + i_imm;
  assign w_byte = (i_op == MEM_LB) || (i_op == MEM_LBU) || (i_op == MEM_SB);
  assign w_half = (i_op == MEM_LH) || (i_op == MEM_LHU) || (i_op == MEM_SH);
  assign w_word = (i_op == MEM_LW) || (i_op == MEM_SW);

  always_comb begin
    o_be       = 4'b0000;
    o_wdata    = i_b2;
    o_misalign = 1'b0;
    o_op       = i_op;
    if (w_byte) begin
      o_be    = 4'b0001 << o_addr[1:0];
      o_wdata = {4{i_b2[7:0]}};
    end else if (w_half) begin
      o_be       = o_addr[1] ? 4'b1100 : 4'b0011;
      o_wdata    = {2{i_b2[15:0]}};
      o_misalign = o_addr[0];
    end else if (w_word) begin
      o_be       = 4'b1111;
      o_misalign = (o_addr[1:0] != 2'b00);
    end else begin
      o_op = MEM_OP_NOP;
    end
    if (o_misalign) begin
      o_be = 4'b0000;
      o_op = MEM_OP_NOP;
    end
  end
endmodule

// File: rtl/rv32i_execute.sv
// RV32I execute stage: forwarding muxes, ALU/branch/LSU and EX/MEM register (1-cycle).
// No stall input: upstream holds or bubbles; flush/br_target are same-cycle.
module rv32i_execute
  import core_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_i,
  input  logic [31:0]     pc_i,
  input  logic [31:0]     rs1_val_i,
  input  logic [31:0]     rs2_val_i,
  input  logic [31:0]     imm_i,
  input  logic [4:0]      rd_i,
  input  logic            rd_we_i,
  input  logic [3:0]      alu_op_i,
  input  logic            src_b_imm_i,
  input  logic [3:0]      br_op_i,
  input  logic [3:0]      mem_op_i,
  input  logic [1:0]      fw_rs1_i,
  input  logic [1:0]      fw_rs2_i,
  input  logic [31:0]     mem_byp_i,
  input  logic [31:0]     wb_byp_i,
  output logic            flush_o,
  output logic [31:0]     br_target_o,
  output logic            valid_o,
  output logic [4:0]      rd_o,
  output logic            rd_we_o,
  output logic [31:0]     rd_res_o,
  output logic [3:0]      mem_op_o,
  output logic [31:0]     mem_addr_o,
  output logic [31:0]     mem_wdata_o,
  output logic [3:0]      mem_be_o,
  output logic            misalign_o
);
  logic [XLEN-1:0] w_a, w_b2, w_b, w_alu_res, w_link, w_addr, w_wdata;
  logic [3:0]      w_be, w_mem_op;
  logic            w_is_jump, w_misalign;

  always_comb begin
    case (fw_rs1_i)
      FW_MEM:  w_a = mem_byp_i;
      FW_WB:   w_a = wb_byp_i;
      default: w_a = rs1_val_i;
    endcase
    case (fw_rs2_i)
      FW_MEM:  w_b2 = mem_byp_i;
      FW_WB:   w_b2 = wb_byp_i;
      default: w_b2 = rs2_val_i;
    endcase
  end

  assign w_b = src_b_imm_i ? imm_i : w_b2;

  ex_alu u_alu (
    .i_op  (alu_op_i),
    .i_a   (w_a),
    .i_b   (w_b),
    .i_pc  (pc_i),
    .o_res (w_alu_res)
  );

  ex_branch u_branch (
    .i_valid   (valid_i),
    .i_op      (br_op_i),
    .i_pc      (pc_i),
    .i_a       (w_a),
    .i_b2      (w_b2),
    .i_imm     (imm_i),
    .o_flush   (flush_o),
    .o_target  (br_target_o),
    .o_is_jump (w_is_jump),
    .o_link    (w_link)
  );

  ex_lsu_ctl u_lsu (
    .i_op       (mem_op_i),
    .i_a        (w_a),
    .i_imm      (imm_i),
    .i_b2       (w_b2),
    .o_addr     (w_addr),
    .o_be       (w_be),
    .o_wdata    (w_wdata),
    .o_misalign (w_misalign),
    .o_op       (w_mem_op)
  );

  // Bubbles load an all-zero record so MEM never acts on stale controls.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst || !valid_i) begin
      valid_o     <= 1'b0;
      rd_o        <= '0;
      rd_we_o     <= 1'b0;
      rd_res_o    <= '0;
      mem_op_o    <= MEM_OP_NOP;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      mem_be_o    <= '0;
      misalign_o  <= 1'b0;
    end else begin
      valid_o     <= 1'b1;
      rd_o        <= rd_i;
      rd_we_o     <= rd_we_i;
      rd_res_o    <= w_is_jump ? w_link : w_alu_res;
      mem_op_o    <= w_mem_op;
      mem_addr_o  <= w_addr;
      mem_wdata_o <= w_wdata;
      mem_be_o    <= w_be;
      misalign_o  <= w_misalign;
    end
  end
endmodule

// File: tb/tb_rv32i_execute.sv
// Directed self-checking bench for rv32i_execute with hand-computed expectations.
module tb_rv32i_execute;
  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i;
  logic [31:0] pc_i, rs1_val_i, rs2_val_i, imm_i, mem_byp_i, wb_byp_i;
  logic [4:0]  rd_i;
  logic        rd_we_i, src_b_imm_i;
  logic [3:0]  alu_op_i, br_op_i, mem_op_i;
  logic [1:0]  fw_rs1_i, fw_rs2_i;
  logic        flush_o, valid_o, rd_we_o, misalign_o;
  logic [31:0] br_target_o, rd_res_o, mem_addr_o, mem_wdata_o;
  logic [4:0]  rd_o;
  logic [3:0]  mem_op_o, mem_be_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rv32i_execute dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .pc_i(pc_i),
    .rs1_val_i(rs1_val_i), .rs2_val_i(rs2_val_i), .imm_i(imm_i),
    .rd_i(rd_i), .rd_we_i(rd_we_i), .alu_op_i(alu_op_i),
    .src_b_imm_i(src_b_imm_i), .br_op_i(br_op_i), .mem_op_i(mem_op_i),
    .fw_rs1_i(fw_rs1_i), .fw_rs2_i(fw_rs2_i),
    .mem_byp_i(mem_byp_i), .wb_byp_i(wb_byp_i),
    .flush_o(flush_o), .br_target_o(br_target_o), .valid_o(valid_o),
    .rd_o(rd_o), .rd_we_o(rd_we_o), .rd_res_o(rd_res_o),
    .mem_op_o(mem_op_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_be_o(mem_be_o), .misalign_o(misalign_o)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Default: valid ALU NOP, no branch, no memory, register-file operands.
  task automatic clr();
    valid_i = 1'b1; pc_i = '0; rs1_val_i = '0; rs2_val_i = '0; imm_i = '0;
    rd_i = '0; rd_we_i = 1'b0; alu_op_i = 4'd15; src_b_imm_i = 1'b0;
    br_op_i = 4'd0; mem_op_i = 4'd0; fw_rs1_i = 2'd0; fw_rs2_i = 2'd0;
    mem_byp_i = '0; wb_byp_i = '0;
  endtask

  task automatic alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic use_imm);
    clr();
    alu_op_i = op; rs1_val_i = a; rd_i = 5'd1; rd_we_i = 1'b1;
    src_b_imm_i = use_imm;
    if (use_imm) imm_i = b; else rs2_val_i = b;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    clr();
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_valid", {31'b0, valid_o}, 32'd0);
    check_eq("reset_memop", {28'b0, mem_op_o}, 32'd0);
    @(negedge clk) rst = 1'b1;

    // SB so the register holds non-zero state before the mid-stream reset.
    clr(); mem_op_i = 4'd6; rs1_val_i = 32'h1000; imm_i = 32'd3; rs2_val_i = 32'hAB;
    step();
    check_eq("sb_be",    {28'b0, mem_be_o}, 32'h8);
    check_eq("sb_wdata", mem_wdata_o, 32'hABABABAB);
    check_eq("sb_addr",  mem_addr_o, 32'h1003);
    check_eq("sb_op",    {28'b0, mem_op_o}, 32'd6);
    #2 rst = 1'b0;
    #1;
    check_eq("arst_valid", {31'b0, valid_o}, 32'd0);
    check_eq("arst_memop", {28'b0, mem_op_o}, 32'd0);
    check_eq("arst_be",    {28'b0, mem_be_o}, 32'd0);
    check_eq("arst_wdata", mem_wdata_o, 32'd0);
    check_eq("arst_addr",  mem_addr_o, 32'd0);
    @(negedge clk) rst = 1'b1;

    clr(); alu_op_i = 4'd0; rs1_val_i = 32'd5; rs2_val_i = 32'd7; rd_i = 5'd3; rd_we_i = 1'b1;
    step();
    check_eq("add_res",   rd_res_o, 32'd12);
    check_eq("add_rd",    {27'b0, rd_o}, 32'd3);
    check_eq("add_rdwe",  {31'b0, rd_we_o}, 32'd1);
    check_eq("add_valid", {31'b0, valid_o}, 32'd1);

    alu(4'd1, 32'd0, 32'd1, 1'b0);                 step(); check_eq("sub_wrap", rd_res_o, 32'hFFFFFFFF);
    alu(4'd7, 32'h80000000, 32'd31, 1'b1);         step(); check_eq("sra_31",   rd_res_o, 32'hFFFFFFFF);
    alu(4'd6, 32'h80000000, 32'd31, 1'b1);         step(); check_eq("srl_31",   rd_res_o, 32'h1);
    alu(4'd2, 32'h1, 32'h24, 1'b1);                step(); check_eq("sll_b40",  rd_res_o, 32'h10);
    alu(4'd3, 32'hFFFFFFFF, 32'd1, 1'b0);          step(); check_eq("slt",      rd_res_o, 32'd1);
    alu(4'd4, 32'hFFFFFFFF, 32'd1, 1'b0);          step(); check_eq("sltu",     rd_res_o, 32'd0);
    alu(4'd5, 32'hF0F0F0F0, 32'h0FF00FF0, 1'b0);   step(); check_eq("xor",      rd_res_o, 32'hFF00FF00);
    alu(4'd10, 32'h5, 32'hABCDE000, 1'b1);         step(); check_eq("lui",      rd_res_o, 32'hABCDE000);
    alu(4'd13, 32'h5, 32'h6, 1'b0);                step(); check_eq("op13_nop", rd_res_o, 32'd0);
    alu(4'd11, 32'h0, 32'h1000, 1'b1); pc_i = 32'h100; step(); check_eq("auipc", rd_res_o, 32'h1100);

    clr(); alu_op_i = 4'd0; rs1_val_i = 32'd1; mem_byp_i = 32'd10; fw_rs1_i = 2'd1;
    rs2_val_i = 32'd2; wb_byp_i = 32'd20; fw_rs2_i = 2'd2;
    step(); check_eq("fwd_mem_wb", rd_res_o, 32'd30);
    clr(); alu_op_i = 4'd0; rs1_val_i = 32'd1; rs2_val_i = 32'd2; mem_byp_i = 32'd9;
    fw_rs1_i = 2'd1; fw_rs2_i = 2'd1;
    step(); check_eq("fwd_same", rd_res_o, 32'd18);
    clr(); alu_op_i = 4'd0; rs1_val_i = 32'd4; rs2_val_i = 32'd6; mem_byp_i = 32'd100;
    wb_byp_i = 32'd200; fw_rs1_i = 2'd3; fw_rs2_i = 2'd3;
    step(); check_eq("fwd_sel3", rd_res_o, 32'd10);

    clr(); br_op_i = 4'd1; rs1_val_i = 32'd5; rs2_val_i = 32'd5; pc_i = 32'h40; imm_i = 32'hFFFFFFF8;
    #1;
    check_eq("beq_flush",  {31'b0, flush_o}, 32'd1);
    check_eq("beq_target", br_target_o, 32'h38);
    br_op_i = 4'd2; #1;
    check_eq("bne_flush",  {31'b0, flush_o}, 32'd0);
    check_eq("bne_target", br_target_o, 32'd0);
    br_op_i = 4'd3; rs1_val_i = 32'hFFFFFFFF; rs2_val_i = 32'd1; #1;
    check_eq("blt_flush",  {31'b0, flush_o}, 32'd1);
    br_op_i = 4'd5; #1;
    check_eq("bltu_flush", {31'b0, flush_o}, 32'd0);
    br_op_i = 4'd1; rs1_val_i = 32'd5; rs2_val_i = 32'd5; valid_i = 1'b0; #1;
    check_eq("beq_bubble_flush", {31'b0, flush_o}, 32'd0);
    step();
    check_eq("bubble_valid", {31'b0, valid_o}, 32'd0);
    check_eq("bubble_memop", {28'b0, mem_op_o}, 32'd0);

    clr(); br_op_i = 4'd8; alu_op_i = 4'd0; src_b_imm_i = 1'b1; rd_i = 5'd1; rd_we_i = 1'b1;
    rs1_val_i = 32'h1001; imm_i = 32'd4; pc_i = 32'h200;
    #1;
    check_eq("jalr_flush",  {31'b0, flush_o}, 32'd1);
    check_eq("jalr_target", br_target_o, 32'h1004);
    step();
    check_eq("jalr_link",   rd_res_o, 32'h204);

    clr(); mem_op_i = 4'd7; rs1_val_i = 32'h1000; imm_i = 32'd2; rs2_val_i = 32'h1234;
    step();
    check_eq("sh_be",       {28'b0, mem_be_o}, 32'hC);
    check_eq("sh_wdata",    mem_wdata_o, 32'h12341234);
    check_eq("sh_misalign", {31'b0, misalign_o}, 32'd0);

    clr(); mem_op_i = 4'd8; rs1_val_i = 32'h1000; imm_i = 32'd2; rs2_val_i = 32'h1234;
    step();
    check_eq("sw_misalign", {31'b0, misalign_o}, 32'd1);
    check_eq("sw_mis_op",   {28'b0, mem_op_o}, 32'd0);
    check_eq("sw_mis_be",   {28'b0, mem_be_o}, 32'd0);

    clr(); mem_op_i = 4'd8; rs1_val_i = 32'h1000; imm_i = 32'd4; rs2_val_i = 32'hDEADBEEF;
    step();
    check_eq("sw_be",    {28'b0, mem_be_o}, 32'hF);
    check_eq("sw_op",    {28'b0, mem_op_o}, 32'd8);
    check_eq("sw_wdata", mem_wdata_o, 32'hDEADBEEF);

    clr(); mem_op_i = 4'd3; rs1_val_i = 32'h1000; imm_i = 32'd4;
    step();
    check_eq("lw_be",    {28'b0, mem_be_o}, 32'hF);
    check_eq("lw_op",    {28'b0, mem_op_o}, 32'd3);

    clr(); mem_op_i = 4'd5; rs1_val_i = 32'h1001;
    step();
    check_eq("lhu_misalign", {31'b0, misalign_o}, 32'd1);
    check_eq("lhu_mis_be",   {28'b0, mem_be_o}, 32'd0);

    clr(); mem_op_i = 4'd4; rs1_val_i = 32'h1001;
    step();
    check_eq("lbu_be", {28'b0, mem_be_o}, 32'h2);

    clr(); mem_op_i = 4'd12; rs1_val_i = 32'h1000;
    step();
    check_eq("memop12_op", {28'b0, mem_op_o}, 32'd0);
    check_eq("memop12_be", {28'b0, mem_be_o}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
